chip8_writeback: RTL and testbench
==================================

# chip8_writeback

Parametrised writeback stage of the CHIP-8 core pipeline. Accepts retired results from execute over a valid/ready handshake and drives the single write port of the V register file. Sequences the two-write "result then VF flag" case and the FX65 load burst (V0..Vx from memory beats), and owns the I register with a selectable FX65 I-increment quirk. Emits one retire pulse per completed instruction.

## Interface
Parameters:
- DATA_W, 8, V register width.
- NREGS, 16, number of V registers; RA_W = $clog2(NREGS); flag register is index NREGS-1.
- I_W, 16, I register width.
- I_INC, 0, 1 = FX65 burst advances I by x+1 (COSMAC quirk); 0 = I unchanged.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  execute result valid.
- in_ready  out  1  stage can accept.
- in_op  in  2  0 NONE, 1 REG, 2 IREG, 3 BURST.
- in_rd  in  RA_W  destination Vx; for BURST, last register x.
- in_data  in  DATA_W  REG result.
- in_flag_we  in  1  REG also writes VF.
- in_flag  in  1  VF value (zero-extended to DATA_W).
- in_i_data  in  I_W  IREG value.
- mem_valid  in  1  burst data beat valid.
- mem_ready  out  1  stage takes burst beats.
- mem_data  in  DATA_W  burst beat.
- rf_we  out  1  register file write enable.
- rf_waddr  out  RA_W  write address.
- rf_wdata  out  DATA_W  write data.
- i_reg  out  I_W  current I register.
- retire  out  1  one-cycle pulse, instruction complete.

## Operation
- States: IDLE, FLAG, BURST. in_ready = (state==IDLE) && rst; mem_ready = (state==BURST).
- Accept = in_valid && in_ready at a rising edge; in_* fields sampled only then.
- NONE: next cycle retire=1, rf_we=0.
- REG, in_flag_we=0: next cycle rf_we=1, rf_waddr=in_rd, rf_wdata=in_data, retire=1.
- REG, in_flag_we=1: next cycle Vx write (retire=0), state FLAG; following cycle rf_we=1, addr NREGS-1, data {0,in_flag}, retire=1, state IDLE. VF write always last, so flag wins when in_rd==NREGS-1.
- IREG: next cycle i_reg=in_i_data, retire=1, rf_we=0.
- BURST: state BURST, counter cnt=0, x=in_rd latched. Each mem_valid beat: next cycle rf_we=1, rf_waddr=cnt, rf_wdata=mem_data, cnt++. Beat with cnt==x: that write carries retire=1, state IDLE, and if I_INC=1 i_reg += x+1 modulo 2^I_W (same cycle as retire).
- Cycles without mem_valid in BURST: rf_we=0, no progress; no timeout.
- mem_valid outside BURST: ignored.
- rf_waddr/rf_wdata hold last value when rf_we=0.

## Timing
- All outputs registered; reset (rst=0 at edge) values: rf_we=0, rf_waddr=0, rf_wdata=0, i_reg=0, retire=0, state IDLE, cnt=0; in_ready and mem_ready 0 while rst=0.
- Latency accept→first write/retire: 1 cycle.
- REG+flag: in_ready low 1 cycle; back-to-back accepts every 2 cycles. Other single ops: 1 accept per cycle, full throughput.
- BURST of x: x+1 beats, write 1 cycle after each beat; in_ready low from accept until edge of final write; minimum x+1 cycles.
- Reset mid-FLAG or mid-BURST: pending writes dropped, no retire, I cleared; first accept possible at first edge with rst=1.
- Burst with x=0: single beat, writes V0, retires; I_INC adds 1.
- I wrap: I=2^I_W-2, I_INC=1, x=3 → I=2.

## Test plan
- Reset: hold rst=0 mid-BURST x=5 after 2 beats, release → rf_we=0, i_reg=0, retire=0, in_ready=1 next cycle, no further writes on extra mem_valid.
- REG stream: ops V3←0x42, V7←0xFF back-to-back → rf_we on 2 consecutive cycles, addrs 3,7, two retire pulses.
- Flag collision: REG in_rd=15, in_data=0x10, flag_we=1, in_flag=1 → write F=0x10, then F=0x01 with retire; in_ready low exactly 1 cycle.
- Burst I_INC=1, I=0x300 via IREG, BURST x=3, beats 0xA0..0xA3 with 1-cycle gaps → V0..V3 = 0xA0..0xA3, single retire on last write, i_reg=0x304; with I_INC=0 i_reg stays 0x300.
- I wrap: I_W=16, IREG 0xFFFE, BURST x=3, I_INC=1 → i_reg=0x0002.
- Stray beats: mem_valid pulses in IDLE then NONE op → no rf_we, one retire, mem_ready=0 throughout.

Source files
------------

// File: rtl/chip8_writeback.sv
// CHIP-8 writeback stage: retires execute results into the V register file write port,
// sequences the VF flag second write and the FX65 load burst, and owns the I register.
module chip8_writeback #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 16,
    parameter int I_W    = 16,
    parameter int I_INC  = 0,
    localparam int RA_W  = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [RA_W-1:0]   in_rd,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_flag_we,
    input  logic              in_flag,
    input  logic [I_W-1:0]    in_i_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [DATA_W-1:0] mem_data,
    output logic              rf_we,
    output logic [RA_W-1:0]   rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [I_W-1:0]    i_reg,
    output logic              retire
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLAG  = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    localparam logic [1:0]      OP_NONE  = 2'd0;
    localparam logic [1:0]      OP_REG   = 2'd1;
    localparam logic [1:0]      OP_IREG  = 2'd2;
    localparam logic [1:0]      OP_BURST = 2'd3;
    localparam logic [RA_W-1:0] FLAG_IDX = RA_W'(NREGS - 1);
    localparam logic            INC_EN   = (I_INC != 0);

    state_t            state_q, state_d;
    logic              rf_we_q, rf_we_d;
    logic [RA_W-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic [I_W-1:0]    i_q, i_d;
    logic              retire_q, retire_d;
    logic [RA_W-1:0]   cnt_q, cnt_d;
    logic [RA_W-1:0]   x_q, x_d;
    logic              flag_q, flag_d;
    logic              accept_s;
    logic              last_beat_s;

    assign in_ready    = (state_q == ST_IDLE) && rst;
    assign mem_ready   = (state_q == ST_BURST) && rst;
    assign accept_s    = in_valid && in_ready;
    assign last_beat_s = mem_valid && (cnt_q == x_q);

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign i_reg    = i_q;
    assign retire   = retire_q;

    // State and registered outputs; reset drops any pending flag/burst work.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            i_q        <= '0;
            retire_q   <= 1'b0;
            cnt_q      <= '0;
            x_q        <= '0;
            flag_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            i_q        <= i_d;
            retire_q   <= retire_d;
            cnt_q      <= cnt_d;
            x_q        <= x_d;
            flag_q     <= flag_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && in_op == OP_BURST) begin
                    state_d = ST_BURST;
                end else if (accept_s && in_op == OP_REG && in_flag_we) begin
                    state_d = ST_FLAG;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLAG:  state_d = ST_IDLE;
            ST_BURST: begin
                if (last_beat_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BURST;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Write port, retire, I register and burst bookkeeping; address/data hold when idle.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        i_d        = i_q;
        retire_d   = 1'b0;
        cnt_d      = cnt_q;
        x_d        = x_q;
        flag_d     = flag_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    case (in_op)
                        OP_NONE: retire_d = 1'b1;
                        OP_REG: begin
                            rf_we_d    = 1'b1;
                            rf_waddr_d = in_rd;
                            rf_wdata_d = in_data;
                            retire_d   = !in_flag_we;
                            flag_d     = in_flag;
                        end
                        OP_IREG: begin
                            i_d      = in_i_data;
                            retire_d = 1'b1;
                        end
                        OP_BURST: begin
                            cnt_d = '0;
                            x_d   = in_rd;
                        end
                        default: retire_d = 1'b0;
                    endcase
                end else begin
                    retire_d = 1'b0;
                end
            end
            ST_FLAG: begin
                rf_we_d    = 1'b1;
                rf_waddr_d = FLAG_IDX;
                rf_wdata_d = {{(DATA_W-1){1'b0}}, flag_q};
                retire_d   = 1'b1;
            end
            ST_BURST: begin
                if (mem_valid) begin
                    rf_we_d    = 1'b1;
                    rf_waddr_d = cnt_q;
                    rf_wdata_d = mem_data;
                    cnt_d      = cnt_q + RA_W'(1);
                    retire_d   = last_beat_s;
                    // COSMAC quirk: I advances past the loaded registers, wrapping at 2^I_W.
                    if (last_beat_s && INC_EN) begin
                        i_d = i_q + I_W'(x_q) + I_W'(1);
                    end else begin
                        i_d = i_q;
                    end
                end else begin
                    rf_we_d = 1'b0;
                end
            end
            default: rf_we_d = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_chip8_writeback.sv
// Directed self-checking bench for chip8_writeback; a second instance with I_INC=0
// shares the stimulus so both I-increment behaviours are observed.
module tb_chip8_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [1:0]  in_op;
    logic [3:0]  in_rd;
    logic [7:0]  in_data;
    logic        in_flag_we;
    logic        in_flag;
    logic [15:0] in_i_data;
    logic        mem_valid;
    logic [7:0]  mem_data;

    logic        in_ready, mem_ready, rf_we, retire;
    logic [3:0]  rf_waddr;
    logic [7:0]  rf_wdata;
    logic [15:0] i_reg;

    logic        in_ready0, mem_ready0, rf_we0, retire0;
    logic [3:0]  rf_waddr0;
    logic [7:0]  rf_wdata0;
    logic [15:0] i_reg0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    chip8_writeback #(.DATA_W(8), .NREGS(16), .I_W(16), .I_INC(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_data(in_data), .in_flag_we(in_flag_we), .in_flag(in_flag),
        .in_i_data(in_i_data), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_data(mem_data), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .i_reg(i_reg), .retire(retire)
    );

    chip8_writeback #(.DATA_W(8), .NREGS(16), .I_W(16), .I_INC(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_op(in_op),
        .in_rd(in_rd), .in_data(in_data), .in_flag_we(in_flag_we), .in_flag(in_flag),
        .in_i_data(in_i_data), .mem_valid(mem_valid), .mem_ready(mem_ready0),
        .mem_data(mem_data), .rf_we(rf_we0), .rf_waddr(rf_waddr0), .rf_wdata(rf_wdata0),
        .i_reg(i_reg0), .retire(retire0)
    );

    // Advance past the next rising edge; inputs are changed and outputs sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        in_valid   = 1'b0;
        in_op      = 2'd0;
        in_rd      = 4'd0;
        in_data    = 8'h00;
        in_flag_we = 1'b0;
        in_flag    = 1'b0;
        in_i_data  = 16'h0000;
        mem_valid  = 1'b0;
        mem_data   = 8'h00;
    endtask

    task automatic test_reset();
        quiet();
        rst = 1'b0;
        step();
        step();
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL rst_we got=%0h exp=0", rf_we); end
        checks++; if (rf_waddr !== 4'd0) begin failures++; $display("FAIL rst_waddr got=%0h exp=0", rf_waddr); end
        checks++; if (rf_wdata !== 8'h00) begin failures++; $display("FAIL rst_wdata got=%0h exp=0", rf_wdata); end
        checks++; if (i_reg !== 16'h0000) begin failures++; $display("FAIL rst_ireg got=%0h exp=0", i_reg); end
        checks++; if (retire !== 1'b0) begin failures++; $display("FAIL rst_retire got=%0h exp=0", retire); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%0h exp=0", in_ready); end
        checks++; if (mem_ready !== 1'b0) begin failures++; $display("FAIL rst_mem_ready got=%0h exp=0", mem_ready); end
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rel_in_ready got=%0h exp=1", in_ready); end
    endtask

    task automatic test_reg_stream();
        in_valid = 1'b1; in_op = 2'd1; in_rd = 4'd3; in_data = 8'h42;
        step();
        checks++; if ({rf_we, rf_waddr, rf_wdata, retire} !== {1'b1, 4'd3, 8'h42, 1'b1}) begin
            failures++; $display("FAIL reg_v3 got=%0h,%0h,%0h,%0h exp=1,3,42,1", rf_we, rf_waddr, rf_wdata, retire); end
        in_rd = 4'd7; in_data = 8'hFF;
        step();
        checks++; if ({rf_we, rf_waddr, rf_wdata, retire} !== {1'b1, 4'd7, 8'hFF, 1'b1}) begin
            failures++; $display("FAIL reg_v7 got=%0h,%0h,%0h,%0h exp=1,7,ff,1", rf_we, rf_waddr, rf_wdata, retire); end
        quiet();
        step();
        checks++; if ({rf_we, rf_waddr, rf_wdata, retire} !== {1'b0, 4'd7, 8'hFF, 1'b0}) begin
            failures++; $display("FAIL reg_hold got=%0h,%0h,%0h,%0h exp=0,7,ff,0", rf_we, rf_waddr, rf_wdata, retire); end
    endtask

    task automatic test_flag_collision();
        in_valid = 1'b1; in_op = 2'd1; in_rd = 4'd15; in_data = 8'h10; in_flag_we = 1'b1; in_flag = 1'b1;
        step();
        quiet();
        checks++; if ({rf_we, rf_waddr, rf_wdata, retire} !== {1'b1, 4'd15, 8'h10, 1'b0}) begin
            failures++; $display("FAIL flag_first got=%0h,%0h,%0h,%0h exp=1,f,10,0", rf_we, rf_waddr, rf_wdata, retire); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flag_busy got=%0h exp=0", in_ready); end
        step();
        checks++; if ({rf_we, rf_waddr, rf_wdata, retire} !== {1'b1, 4'd15, 8'h01, 1'b1}) begin
            failures++; $display("FAIL flag_second got=%0h,%0h,%0h,%0h exp=1,f,1,1", rf_we, rf_waddr, rf_wdata, retire); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flag_ready got=%0h exp=1", in_ready); end
    endtask

    // Loads I, then runs a BURST of x=3 with optional idle cycles between beats.
    task automatic run_burst(input logic [15:0] i_val, input logic [7:0] base, input bit gaps,
                             input string tag);
        in_valid = 1'b1; in_op = 2'd2; in_i_data = i_val;
        step();
        checks++; if ({i_reg, retire, rf_we} !== {i_val, 1'b1, 1'b0}) begin
            failures++; $display("FAIL %s_ireg got=%0h,%0h,%0h exp=%0h,1,0", tag, i_reg, retire, rf_we, i_val); end
        in_op = 2'd3; in_rd = 4'd3;
        step();
        quiet();
        checks++; if ({mem_ready, in_ready, rf_we, retire} !== 4'b1000) begin
            failures++; $display("FAIL %s_start got=%b%b%b%b exp=1000", tag, mem_ready, in_ready, rf_we, retire); end
        for (int k = 0; k < 4; k++) begin
            mem_valid = 1'b1; mem_data = base + 8'(k);
            step();
            mem_valid = 1'b0;
            checks++; if ({rf_we, rf_waddr, rf_wdata, retire} !== {1'b1, 4'(k), base + 8'(k), k == 3}) begin
                failures++; $display("FAIL %s_beat%0d got=%0h,%0h,%0h,%0h exp=1,%0h,%0h,%0h", tag, k,
                                     rf_we, rf_waddr, rf_wdata, retire, k, base + 8'(k), k == 3); end
            if (gaps && k < 3) begin
                step();
                checks++; if ({rf_we, retire, mem_ready} !== 3'b001) begin
                    failures++; $display("FAIL %s_gap%0d got=%b%b%b exp=001", tag, k, rf_we, retire, mem_ready); end
            end
        end
        checks++; if ({in_ready, mem_ready} !== 2'b10) begin
            failures++; $display("FAIL %s_done got=%b%b exp=10", tag, in_ready, mem_ready); end
    endtask

    task automatic test_burst_inc();
        run_burst(16'h0300, 8'hA0, 1'b1, "burst");
        checks++; if (i_reg !== 16'h0304) begin failures++; $display("FAIL burst_inc got=%0h exp=304", i_reg); end
        checks++; if (i_reg0 !== 16'h0300) begin failures++; $display("FAIL burst_noinc got=%0h exp=300", i_reg0); end
    endtask

    task automatic test_i_wrap();
        run_burst(16'hFFFE, 8'h30, 1'b0, "wrap");
        checks++; if (i_reg !== 16'h0002) begin failures++; $display("FAIL wrap_inc got=%0h exp=2", i_reg); end
        checks++; if (i_reg0 !== 16'hFFFE) begin failures++; $display("FAIL wrap_noinc got=%0h exp=fffe", i_reg0); end
    endtask

    task automatic test_stray_beats();
        for (int k = 0; k < 3; k++) begin
            mem_valid = 1'b1; mem_data = 8'hEE;
            step();
            checks++; if ({rf_we, retire, mem_ready} !== 3'b000) begin
                failures++; $display("FAIL stray%0d got=%b%b%b exp=000", k, rf_we, retire, mem_ready); end
        end
        in_valid = 1'b1; in_op = 2'd0;
        step();
        in_valid = 1'b0;
        checks++; if ({rf_we, retire, mem_ready} !== 3'b010) begin
            failures++; $display("FAIL none_op got=%b%b%b exp=010", rf_we, retire, mem_ready); end
        step();
        quiet();
        checks++; if ({rf_we, retire, mem_ready} !== 3'b000) begin
            failures++; $display("FAIL none_after got=%b%b%b exp=000", rf_we, retire, mem_ready); end
    endtask

    task automatic test_reset_mid_burst();
        in_valid = 1'b1; in_op = 2'd3; in_rd = 4'd5;
        step();
        quiet();
        for (int k = 0; k < 2; k++) begin
            mem_valid = 1'b1; mem_data = 8'h60 + 8'(k);
            step();
        end
        checks++; if ({rf_we, rf_waddr, retire} !== {1'b1, 4'd1, 1'b0}) begin
            failures++; $display("FAIL mid_beat got=%0h,%0h,%0h exp=1,1,0", rf_we, rf_waddr, retire); end
        rst = 1'b0;
        step();
        checks++; if ({rf_we, retire, i_reg} !== {1'b0, 1'b0, 16'h0000}) begin
            failures++; $display("FAIL mid_rst got=%0h,%0h,%0h exp=0,0,0", rf_we, retire, i_reg); end
        checks++; if ({in_ready, mem_ready} !== 2'b00) begin
            failures++; $display("FAIL mid_rst_rdy got=%b%b exp=00", in_ready, mem_ready); end
        rst = 1'b1;
        #1;
        checks++; if ({in_ready, mem_ready} !== 2'b10) begin
            failures++; $display("FAIL mid_rel_rdy got=%b%b exp=10", in_ready, mem_ready); end
        for (int k = 0; k < 2; k++) begin
            step();
            checks++; if ({rf_we, retire} !== 2'b00) begin
                failures++; $display("FAIL mid_stale%0d got=%b%b exp=00", k, rf_we, retire); end
        end
        quiet();
    endtask

    task automatic test_burst_x0();
        in_valid = 1'b1; in_op = 2'd3; in_rd = 4'd0;
        step();
        quiet();
        mem_valid = 1'b1; mem_data = 8'h5A;
        step();
        mem_valid = 1'b0;
        checks++; if ({rf_we, rf_waddr, rf_wdata, retire} !== {1'b1, 4'd0, 8'h5A, 1'b1}) begin
            failures++; $display("FAIL x0_write got=%0h,%0h,%0h,%0h exp=1,0,5a,1", rf_we, rf_waddr, rf_wdata, retire); end
        checks++; if ({i_reg, i_reg0} !== {16'h0001, 16'h0000}) begin
            failures++; $display("FAIL x0_ireg got=%0h,%0h exp=1,0", i_reg, i_reg0); end
        step();
        checks++; if ({rf_we, retire} !== 2'b00) begin
            failures++; $display("FAIL x0_after got=%b%b exp=00", rf_we, retire); end
    endtask

    initial begin
        test_reset();
        test_reg_stream();
        test_flag_collision();
        test_burst_inc();
        test_i_wrap();
        test_stray_beats();
        test_reset_mid_burst();
        test_burst_x0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
